// File: rtl/fp_counter_pkg.sv
// Shared widths and combinational helpers for the multi-channel floating-step counter:
// step-code expansion and the sign/exponent/mantissa log compression of an accumulator.
package fp_counter_pkg;

    localparam int ACC_W   = 30;
    localparam int STEP_MW = 4;
    localparam int STEP_EW = 4;
    localparam int EXP_W   = 4;
    localparam int MAN_W   = 3;

    localparam int STEP_W = STEP_EW + STEP_MW;
    localparam int E_MAX  = 2**EXP_W - 1;
    localparam int OUT_W  = 1 + EXP_W + MAN_W;
    localparam int B      = ACC_W - 1 - E_MAX;

    // Implicit-1 mantissa shifted left by the exponent field.
    function automatic logic [ACC_W-1:0] step_inc(input logic [STEP_W-1:0] code);
        return ACC_W'({1'b1, code[STEP_MW-1:0]}) << code[STEP_W-1 -: STEP_EW];
    endfunction

    // Leading-one search runs over the ones'-complement magnitude, but the mantissa
    // bits come from the raw accumulator so negative codes keep their two's-complement bits.
    function automatic logic [OUT_W-1:0] encode(input logic [ACC_W-1:0] acc);
        logic             s;
        logic [E_MAX-1:0] mag_hi;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] man;
        s      = acc[ACC_W-1];
        mag_hi = acc[ACC_W-2:B] ^ {E_MAX{s}};
        e      = '0;
        man    = acc[B-1 -: MAN_W];
        for (int j = 0; j < E_MAX; j++) begin
            if (mag_hi[j]) begin
                e   = EXP_W'(j + 1);
                man = acc[B+j-1 -: MAN_W];
            end
        end
        return {s, (s ? ~e : e), man};
    endfunction

endpackage

// File: rtl/fp_acc_channel.sv
// One counter channel: signed accumulator with wrap/saturate stepping, sticky
// overflow flag and a registered log-coded view of the accumulator.
module fp_acc_channel
    import fp_counter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              sat_mode,
    input  logic [STEP_W-1:0] step,
    input  logic              step_en,
    input  logic              step_dn,
    input  logic              clr,
    output logic [OUT_W-1:0]  value,
    output logic              ovf
);

    logic [ACC_W-1:0] acc_reg, acc_next;
    logic             ovf_reg, ovf_next;
    logic [OUT_W-1:0] value_reg;
    logic [ACC_W-1:0] inc;
    logic [ACC_W:0]   sum;
    logic             overflow;

    always_comb begin
        inc = step_inc(step);
        // One guard bit: the result is out of range exactly when the top two bits differ.
        if (step_dn) begin
            sum = {acc_reg[ACC_W-1], acc_reg} - {1'b0, inc};
        end else begin
            sum = {acc_reg[ACC_W-1], acc_reg} + {1'b0, inc};
        end
        overflow = sum[ACC_W] ^ sum[ACC_W-1];

        acc_next = acc_reg;
        ovf_next = ovf_reg;
        if (clr) begin
            acc_next = '0;
            ovf_next = 1'b0;
        end else if (step_en) begin
            acc_next = sum[ACC_W-1:0];
            if (overflow) begin
                ovf_next = 1'b1;
                if (sat_mode) begin
                    acc_next = step_dn ? {1'b1, {(ACC_W-1){1'b0}}}
                                       : {1'b0, {(ACC_W-1){1'b1}}};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg   <= '0;
            ovf_reg   <= 1'b0;
            value_reg <= '0;
        end else begin
            acc_reg   <= acc_next;
            ovf_reg   <= ovf_next;
            value_reg <= encode(acc_reg);
        end
    end

    assign value = value_reg;
    assign ovf   = ovf_reg;

endmodule

// File: rtl/fp_counter_mc.sv
// Multi-channel floating-step counter: N_CH independent accumulator channels
// sharing one clock, reset and wrap/saturate mode, with flat per-channel buses.
module fp_counter_mc
    import fp_counter_pkg::*;
#(
    parameter int N_CH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sat_mode,
    input  logic [N_CH*STEP_W-1:0]   step,
    input  logic [N_CH-1:0]          step_en,
    input  logic [N_CH-1:0]          step_dn,
    input  logic [N_CH-1:0]          clr,
    output logic [N_CH*OUT_W-1:0]    value,
    output logic [N_CH-1:0]          ovf
);

    // The largest step must fit below the sign bit and the e=0 band must hold a full mantissa.
    if ((STEP_MW + 2**STEP_EW > ACC_W - 1) || (B < MAN_W) || (N_CH < 1)) begin : g_bad_cfg
        $error("fp_counter_mc: illegal configuration");
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        fp_acc_channel u_ch (
            .clk      (clk),
            .rst      (rst),
            .sat_mode (sat_mode),
            .step     (step[gi*STEP_W +: STEP_W]),
            .step_en  (step_en[gi]),
            .step_dn  (step_dn[gi]),
            .clr      (clr[gi]),
            .value    (value[gi*OUT_W +: OUT_W]),
            .ovf      (ovf[gi])
        );
    end

endmodule

// File: tb/tb_fp_counter_mc.sv
// Scoreboard bench for fp_counter_mc: directed scenarios plus random traffic
// compared against an arithmetic reference model of each channel.
module tb_fp_counter_mc;

    localparam int N_CH   = 2;
    localparam int ACC_W  = 30;
    localparam int B      = 14;
    localparam int MAN_W  = 3;
    localparam int STEP_W = 8;
    localparam int OUT_W  = 8;
    localparam longint SPAN = longint'(1) << ACC_W;
    localparam longint MAXV = (longint'(1) << (ACC_W-1)) - 1;
    localparam longint MINV = -(longint'(1) << (ACC_W-1));

    logic                    clk;
    logic                    rst;
    logic                    sat_mode;
    logic [N_CH*STEP_W-1:0]  step;
    logic [N_CH-1:0]         step_en;
    logic [N_CH-1:0]         step_dn;
    logic [N_CH-1:0]         clr;
    logic [N_CH*OUT_W-1:0]   value;
    logic [N_CH-1:0]         ovf;

    fp_counter_mc #(.N_CH(N_CH)) dut (
        .clk      (clk),
        .rst      (rst),
        .sat_mode (sat_mode),
        .step     (step),
        .step_en  (step_en),
        .step_dn  (step_dn),
        .clr      (clr),
        .value    (value),
        .ovf      (ovf)
    );

    typedef struct {
        logic [N_CH*OUT_W-1:0] val;
        logic [N_CH-1:0]       ovf;
    } exp_t;

    exp_t   exp_q[$];
    int     checks   = 0;
    int     failures = 0;
    longint m_acc[N_CH];
    bit     m_ovf[N_CH];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference log code from the arithmetic value of the accumulator.
    function automatic logic [7:0] enc(input longint a);
        bit         s;
        longint     mag;
        longint     mant;
        int         p;
        logic [3:0] e;
        s   = (a < 0);
        mag = s ? (-a - 1) : a;
        if (mag < (longint'(1) << B)) begin
            e    = 4'd0;
            mant = (a >>> (B - MAN_W)) & 7;
        end else begin
            p = 0;
            while ((mag >> (p + 1)) != 0) p++;
            e    = 4'(p - B + 1);
            mant = (a >>> (p - MAN_W)) & 7;
        end
        return {s, (s ? ~e : e), 3'(mant)};
    endfunction

    // Drive one cycle of stimulus, advance the model and queue the expected output for that edge.
    task automatic tick(input logic r, input logic sm, input logic [N_CH*STEP_W-1:0] st,
                        input logic [N_CH-1:0] en, input logic [N_CH-1:0] dn,
                        input logic [N_CH-1:0] cl);
        exp_t       e;
        logic [7:0] code;
        longint     inc;
        longint     nr;
        @(negedge clk);
        rst = r; sat_mode = sm; step = st; step_en = en; step_dn = dn; clr = cl;
        for (int ch = 0; ch < N_CH; ch++) begin
            code = st[ch*STEP_W +: STEP_W];
            e.val[ch*OUT_W +: OUT_W] = r ? 8'h00 : enc(m_acc[ch]);
            if (r || cl[ch]) begin
                m_acc[ch] = 0;
                m_ovf[ch] = 0;
            end else if (en[ch]) begin
                inc = longint'(16 + int'(code[3:0])) << code[7:4];
                nr  = dn[ch] ? (m_acc[ch] - inc) : (m_acc[ch] + inc);
                if (nr > MAXV || nr < MINV) begin
                    m_ovf[ch] = 1;
                    if (sm) nr = (nr > MAXV) ? MAXV : MINV;
                    else    nr = (nr > MAXV) ? (nr - SPAN) : (nr + SPAN);
                end
                m_acc[ch] = nr;
            end
            e.ovf[ch] = m_ovf[ch];
        end
        exp_q.push_back(e);
    endtask

    task automatic wait_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ch(input string name, input int ch, input logic [7:0] v, input logic o);
        checks++;
        if (value[ch*OUT_W +: OUT_W] !== v || ovf[ch] !== o) begin
            failures++;
            $display("FAIL %s ch%0d got value=%h ovf=%b expected value=%h ovf=%b",
                     name, ch, value[ch*OUT_W +: OUT_W], ovf[ch], v, o);
        end
    endtask

    // Monitor: every edge that follows a stimulus cycle yields one expected record.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int ch = 0; ch < N_CH; ch++) begin
                    checks++;
                    if (value[ch*OUT_W +: OUT_W] !== e.val[ch*OUT_W +: OUT_W]) begin
                        failures++;
                        $display("FAIL value ch%0d t=%0t got=%h exp=%h", ch, $time,
                                 value[ch*OUT_W +: OUT_W], e.val[ch*OUT_W +: OUT_W]);
                    end
                    checks++;
                    if (ovf[ch] !== e.ovf[ch]) begin
                        failures++;
                        $display("FAIL ovf ch%0d t=%0t got=%b exp=%b", ch, $time,
                                 ovf[ch], e.ovf[ch]);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic                   sm;
        logic [N_CH*STEP_W-1:0] st;
        logic [N_CH-1:0]        en, dn, cl;
        logic                   r;
        for (int ch = 0; ch < N_CH; ch++) begin
            m_acc[ch] = 0;
            m_ovf[ch] = 0;
        end

        tick(1, 0, '0, '0, '0, '0);
        tick(1, 0, '0, '0, '0, '0);
        wait_edge();
        check_ch("reset", 0, 8'h00, 0);
        check_ch("reset", 1, 8'h00, 0);
        $display("txn reset done");

        tick(0, 0, 16'h0000, 2'b01, 2'b00, 2'b00);
        tick(0, 0, '0, '0, '0, '0);
        wait_edge();
        check_ch("step_00_up", 0, 8'h00, 0);
        $display("txn step 00 up");

        tick(0, 0, '0, '0, '0, 2'b11);
        tick(0, 0, 16'h00F0, 2'b01, 2'b00, 2'b00);
        tick(0, 0, '0, '0, '0, '0);
        wait_edge();
        check_ch("step_f0_up", 0, 8'h30, 0);
        $display("txn step f0 up");

        tick(0, 0, '0, '0, '0, 2'b11);
        tick(0, 0, 16'h00F0, 2'b01, 2'b01, 2'b00);
        tick(0, 0, '0, '0, '0, '0);
        wait_edge();
        check_ch("step_f0_dn", 0, 8'hD0, 0);
        $display("txn step f0 down");

        tick(0, 1, '0, '0, '0, 2'b11);
        for (int i = 0; i < 1027; i++) tick(0, 1, 16'h00F0, 2'b01, 2'b00, 2'b00);
        tick(0, 1, '0, '0, '0, '0);
        wait_edge();
        check_ch("sat_up", 0, 8'h7F, 1);
        $display("txn saturate 1027 steps up");

        tick(0, 0, '0, '0, '0, 2'b11);
        for (int i = 0; i < 1024; i++) tick(0, 0, 16'h00F0, 2'b01, 2'b00, 2'b00);
        tick(0, 0, '0, '0, '0, '0);
        wait_edge();
        check_ch("wrap_up", 0, 8'h80, 1);
        tick(0, 0, '0, '0, '0, 2'b01);
        wait_edge();
        check_ch("clr_ovf", 0, 8'h80, 0);
        tick(0, 0, '0, '0, '0, '0);
        wait_edge();
        check_ch("clr_value", 0, 8'h00, 0);
        $display("txn wrap 1024 steps then clear");

        tick(0, 0, '0, '0, '0, 2'b11);
        tick(0, 0, 16'hF0F0, 2'b11, 2'b00, 2'b01);
        tick(0, 0, '0, '0, '0, '0);
        wait_edge();
        check_ch("xch_clr", 0, 8'h00, 0);
        check_ch("xch_step", 1, 8'h30, 0);
        $display("txn clr+step ch0 with ch1 stepping");

        for (int i = 0; i < 3; i++) tick(0, 0, 16'hF0F0, 2'b11, 2'b00, 2'b00);
        tick(1, 0, 16'hF0F0, 2'b11, 2'b00, 2'b00);
        wait_edge();
        check_ch("rst_mid", 0, 8'h00, 0);
        check_ch("rst_mid", 1, 8'h00, 0);
        tick(0, 0, '0, '0, '0, '0);
        wait_edge();
        check_ch("rst_mid_acc", 0, 8'h00, 0);
        check_ch("rst_mid_acc", 1, 8'h00, 0);
        $display("txn reset mid-sequence");

        sm = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) sm = ~sm;
            r  = ($urandom_range(0, 199) == 0);
            st = N_CH*STEP_W'($urandom);
            en = N_CH'($urandom);
            dn = N_CH'($urandom);
            cl = '0;
            for (int ch = 0; ch < N_CH; ch++) cl[ch] = ($urandom_range(0, 29) == 0);
            tick(r, sm, st, en, dn, cl);
        end
        tick(0, 0, '0, '0, '0, '0);
        tick(0, 0, '0, '0, '0, '0);
        wait_edge();
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d pending expected=0", exp_q.size());
        end
        $display("txn random traffic done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
